// File: rtl/md_unit_if.sv
// EX-stage multiply/divide port bundle: operands and controls in; busy and HI/LO out.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, hilo_we, hilo_sel, a, b, flush,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, hilo_we, hilo_sel, a, b, flush,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Define MD_MADD_EN to make ops 4-7 (madd/maddu/msub/msubu) accumulate; otherwise they are no-ops.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md
);
    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {ACC_LOAD, ACC_ADD, ACC_SUB} acc_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   pend_q, pend_d;
    logic          commit_q, commit_d;
    acc_t          acc_q, acc_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    // Operand decode; bit 0 of md_op selects unsigned for every op family.
    logic        op_signed, is_div, is_madd, op_valid;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

    always_comb begin
        op_signed = ~md.md_op[0];
        is_div    = (md.md_op[2:1] == 2'b01);
        is_madd   = md.md_op[2];
`ifdef MD_MADD_EN
        op_valid  = 1'b1;
`else
        op_valid  = ~is_madd;
`endif
        a_ext = {{32{op_signed & md.a[31]}}, md.a};
        b_ext = {{32{op_signed & md.b[31]}}, md.b};
        prod  = a_ext * b_ext;

        // Divide on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
        a_neg   = op_signed & md.a[31];
        b_neg   = op_signed & md.b[31];
        a_mag   = a_neg ? (32'd0 - md.a) : md.a;
        b_mag   = b_neg ? (32'd0 - md.b) : md.b;
        divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        commit_d = commit_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (md.start && !md.flush) begin
                    if (op_valid) begin
                        state_d  = BUSY;
                        cnt_d    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        pend_d   = is_div ? {rem, quot} : prod;
                        commit_d = !(is_div && (md.b == 32'd0));
                        if (is_madd)
                            acc_d = md.md_op[1] ? ACC_SUB : ACC_ADD;
                        else
                            acc_d = ACC_LOAD;
                    end
                end else if (md.hilo_we && !md.flush) begin
                    if (md.hilo_sel)
                        hi_d = md.a;
                    else
                        lo_d = md.a;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (commit_q) begin
                        case (acc_q)
                            ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
                            ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
                            default: {hi_d, lo_d} = pend_q;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            commit_q <= 1'b0;
            acc_q    <= ACC_LOAD;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            commit_q <= commit_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign md.busy = (state_q == BUSY);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, mult/div results, HI/LO writes, flush and reset.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and follow it to completion, checking busy timing and HI/LO before/after.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int n,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        bit held;
        bus.start = 1'b1;
        bus.md_op = op;
        bus.a     = av;
        bus.b     = bv;
        tick();
        bus.start = 1'b0;
        held = 1'b1;
        for (int i = 1; i < n; i++) begin
            if (bus.busy !== 1'b1 || bus.hi !== old_hi || bus.lo !== old_lo) held = 1'b0;
            tick();
        end
        checks++;
        if (!held || bus.busy !== 1'b1 || bus.hi !== old_hi || bus.lo !== old_lo) begin
            errors++;
            $display("FAIL %s_inflight: busy=%b hi=%h lo=%h, required busy=1 hi=%h lo=%h for %0d cycles",
                     name, bus.busy, bus.hi, bus.lo, old_hi, old_lo, n);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL %s_done: busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h",
                     name, bus.busy, bus.hi, bus.lo, exp_hi, exp_lo);
        end
        $display("op %s a=%h b=%h -> hi=%h lo=%h", name, av, bv, bus.hi, bus.lo);
    endtask

    task automatic write_hilo(input logic sel, input logic [31:0] v);
        bus.hilo_we  = 1'b1;
        bus.hilo_sel = sel;
        bus.a        = v;
        tick();
        bus.hilo_we  = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h, required 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        $display("reset: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    endtask

    task automatic test_mult();
        run_op("mult",  3'd0, 32'hFFFFFFFF, 32'd2, MC, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, MC, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE);
        run_op("mult_pos", 3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, MC, 32'h1, 32'hFFFFFFFE,
               32'h3FFFFFFF, 32'h00000001);
    endtask

    task automatic test_div();
        run_op("div_neg",  3'd2, 32'hFFFFFFF9, 32'd2, DC, 32'h3FFFFFFF, 32'h00000001,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",     3'd3, 32'd7, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd3);
        run_op("div_negb", 3'd2, 32'd7, 32'hFFFFFFFE, DC, 32'd1, 32'd3, 32'd1, 32'hFFFFFFFD);
        run_op("div_ovf",  3'd2, 32'h80000000, 32'hFFFFFFFF, DC, 32'd1, 32'hFFFFFFFD,
               32'd0, 32'h80000000);
        run_op("div_zero", 3'd2, 32'd5, 32'd0, DC, 32'd0, 32'h80000000, 32'd0, 32'h80000000);
    endtask

    task automatic test_hilo();
        write_hilo(1'b1, 32'h1234);
        checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h80000000) begin
            errors++;
            $display("FAIL mthi_idle: hi=%h lo=%h, required hi=00001234 lo=80000000", bus.hi, bus.lo);
        end
        write_hilo(1'b0, 32'hCAFE);
        checks++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'hCAFE) begin
            errors++;
            $display("FAIL mtlo_idle: hi=%h lo=%h, required hi=00001234 lo=0000cafe", bus.hi, bus.lo);
        end
        bus.flush = 1'b1;
        write_hilo(1'b1, 32'h5555);
        bus.flush = 1'b0;
        checks++;
        if (bus.hi !== 32'h1234) begin
            errors++;
            $display("FAIL mthi_flush: hi=%h, required 00001234", bus.hi);
        end
        $display("hilo: hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    // mthi and a second start during BUSY must both be ignored.
    task automatic test_busy_ignore();
        bus.start = 1'b1;
        bus.md_op = 3'd1;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        tick();
        bus.start = 1'b0;
        write_hilo(1'b1, 32'h9999);
        bus.start = 1'b1;
        bus.md_op = 3'd3;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.hi !== 32'h1234 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mthi: hi=%h busy=%b, required hi=00001234 busy=1", bus.hi, bus.busy);
        end
        repeat (MC - 2) tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
            errors++;
            $display("FAIL busy_start: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0000000c",
                     bus.busy, bus.hi, bus.lo);
        end
        $display("busy_ignore: hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    task automatic test_flush_start();
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.md_op = 3'd0;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_busy: busy=%b, required 0", bus.busy);
        end
        repeat (MC + 1) tick();
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd12) begin
            errors++;
            $display("FAIL flush_start_hilo: hi=%h lo=%h, required 0/0000000c", bus.hi, bus.lo);
        end
        $display("flush_start: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    endtask

    task automatic test_madd();
        write_hilo(1'b1, 32'd0);
        write_hilo(1'b0, 32'hFFFFFFFF);
`ifdef MD_MADD_EN
        run_op("maddu", 3'd5, 32'd1, 32'd1, MC, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0);
        run_op("msub",  3'd6, 32'd2, 32'hFFFFFFFF, MC, 32'd1, 32'd0, 32'd1, 32'd2);
`else
        bus.start = 1'b1;
        bus.md_op = 3'd5;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL madd_off_busy: busy=%b, required 0", bus.busy);
        end
        repeat (MC + 1) tick();
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'hFFFFFFFF || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL madd_off_hilo: busy=%b hi=%h lo=%h, required 0/0/ffffffff",
                     bus.busy, bus.hi, bus.lo);
        end
        $display("madd_off: hi=%h lo=%h", bus.hi, bus.lo);
`endif
    endtask

    // Async reset three cycles into a divide clears everything without waiting for a clock edge.
    task automatic test_reset_mid();
        write_hilo(1'b1, 32'hAAAA);
        bus.start = 1'b1;
        bus.md_op = 3'd2;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h, required 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        tick();
        reset = 1'b1;
        repeat (DC) tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_after: busy=%b hi=%h lo=%h, required 0/0/0",
                     bus.busy, bus.hi, bus.lo);
        end
        $display("reset_mid: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.md_op    = 3'd0;
        bus.hilo_we  = 1'b0;
        bus.hilo_sel = 1'b0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.flush    = 1'b0;
        tick();
        tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_mult();
        test_div();
        test_hilo();
        test_busy_ignore();
        test_flush_start();
        test_madd();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
